// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: shift type codes,
// the width-independent control part of a stage payload, and a helper that
// sizes the flattened payload vector for a given operand width.
package shift_pkg;

    localparam logic [2:0] SH_LSL = 3'b000;
    localparam logic [2:0] SH_LSR = 3'b001;
    localparam logic [2:0] SH_ASR = 3'b010;
    localparam logic [2:0] SH_ROL = 3'b011;
    localparam logic [2:0] SH_ROR = 3'b100;

    // typ   : shift type code
    // sat   : amount out of range for a non-rotate type; final stage overrides data
    // nz    : original amount was non-zero (rotate carry is forced to 0 otherwise)
    // carry : non-rotate carry, resolved at decode time
    // fill  : bit shifted in from the left (sign for ASR, else 0)
    typedef struct packed {
        logic [2:0] typ;
        logic       sat;
        logic       nz;
        logic       carry;
        logic       fill;
    } stage_ctrl_t;

    // Stage payload = data + in-range shift amount bits + control.
    // Modules declare their own WIDTH-dependent struct and exchange it as a
    // flat vector of this width.
    function automatic int payload_w(input int width);
        return width + $clog2(width) + $bits(stage_ctrl_t);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the barrel shifter: conditionally shifts/rotates by
// 2**K when amount bit K is set, then registers valid + payload under the
// global advance enable. The last stage also applies the out-of-range override.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 0,
    parameter bit LAST  = 1'b0,
    localparam int NSTG = $clog2(WIDTH),
    localparam int PW   = payload_w(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          valid_i,
    input  logic [PW-1:0] pld_i,
    output logic          valid_o,
    output logic [PW-1:0] pld_o
);

    localparam int SH = 2 ** K;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [NSTG-1:0]  shamt;
        stage_ctrl_t      ctrl;
    } payload_t;

    payload_t pld_in;
    payload_t pld_d;
    payload_t pld_q;
    logic     valid_q;

    assign pld_in = pld_i;

    // Conditional shift by 2**K; out-of-range results collapse to the fill pattern at the end.
    always_comb begin
        pld_d = pld_in;
        if (pld_in.shamt[K]) begin
            case (pld_in.ctrl.typ)
                SH_LSL:  pld_d.data = pld_in.data << SH;
                SH_LSR:  pld_d.data = pld_in.data >> SH;
                SH_ASR:  pld_d.data = (pld_in.data >> SH)
                                    | ({WIDTH{pld_in.ctrl.fill}} << (WIDTH - SH));
                SH_ROL:  pld_d.data = (pld_in.data << SH) | (pld_in.data >> (WIDTH - SH));
                SH_ROR:  pld_d.data = (pld_in.data >> SH) | (pld_in.data << (WIDTH - SH));
                default: pld_d.data = pld_in.data;
            endcase
        end
        if (LAST && pld_in.ctrl.sat) begin
            pld_d.data = {WIDTH{pld_in.ctrl.fill}};
        end
    end

    // Stage register: every stage loads from its predecessor together, or all hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pld_q   <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            pld_q   <= pld_d;
        end
    end

    assign valid_o = valid_q;
    assign pld_o   = pld_q;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROL/ROR/pass) with valid/ready on both
// sides. Stage-0 decode resolves type, range and non-rotate carry up front; a
// chain of shift_stage instances does one log2 step each; rotate carry and the
// zero flag come combinationally from the final register.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_type,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_carry,
    output logic               out_zero
);

    localparam int NSTG = $clog2(WIDTH);
    localparam int PW   = payload_w(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [NSTG-1:0]  shamt;
        stage_ctrl_t      ctrl;
    } payload_t;

    payload_t       dec;
    payload_t       fin;
    logic           oor;
    logic           en;
    logic [PW-1:0]  pld_chain [NSTG+1];
    logic           vld_chain [NSTG+1];
    logic           unused_fin;

    // No bubble compression: the whole pipe advances whenever the output slot can move.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage-0 decode: range check, saturate flag, fill bit and the non-rotate carry.
    always_comb begin
        dec            = '0;
        dec.data       = in_data;
        dec.shamt      = in_shamt[NSTG-1:0];
        dec.ctrl.typ   = in_type;
        oor            = (in_shamt >> NSTG) != '0;
        dec.ctrl.nz    = (in_shamt != '0);
        dec.ctrl.sat   = oor && ((in_type == SH_LSL) || (in_type == SH_LSR)
                                 || (in_type == SH_ASR));
        dec.ctrl.fill  = (in_type == SH_ASR) && in_data[WIDTH-1];
        dec.ctrl.carry = 1'b0;
        case (in_type)
            SH_LSL: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (in_shamt == SHAMT_W'(WIDTH - i)) dec.ctrl.carry = in_data[i];
                end
            end
            SH_LSR, SH_ASR: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (in_shamt == SHAMT_W'(i + 1)) dec.ctrl.carry = in_data[i];
                end
                if ((in_type == SH_ASR) && (in_shamt >= SHAMT_W'(WIDTH))) begin
                    dec.ctrl.carry = in_data[WIDTH-1];
                end
            end
            default: dec.ctrl.carry = 1'b0;
        endcase
    end

    assign pld_chain[0] = dec;
    assign vld_chain[0] = in_valid;

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .K     (k),
            .LAST  (k == NSTG - 1)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (en),
            .valid_i (vld_chain[k]),
            .pld_i   (pld_chain[k]),
            .valid_o (vld_chain[k+1]),
            .pld_o   (pld_chain[k+1])
        );
    end

    assign fin        = pld_chain[NSTG];
    assign out_valid  = vld_chain[NSTG];
    assign out_data   = fin.data;
    assign out_zero   = (fin.data == '0);
    assign unused_fin = ^{fin.shamt, fin.ctrl.sat, fin.ctrl.fill};

    // Rotate carry is the bit that wrapped last; a zero amount never produces a carry.
    always_comb begin
        out_carry = fin.ctrl.carry;
        if (fin.ctrl.nz && (fin.ctrl.typ == SH_ROL)) out_carry = fin.data[0];
        if (fin.ctrl.nz && (fin.ctrl.typ == SH_ROR)) out_carry = fin.data[WIDTH-1];
    end

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (WIDTH=8): directed cases, streaming with
// backpressure, mid-stream reset and a long randomized run scored against a
// behavioural model.
module tb_shift_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [4:0] in_shamt;
    logic [2:0] in_type;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_carry;
    logic       out_zero;

    int n_chk   = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int out_cnt = 0;
    int acc_cnt = 0;

    logic [8:0] q_exp [$];
    int         oc_q  [$];
    logic [8:0] e;
    logic       stall_q = 1'b0;
    logic [7:0] hold_d;
    logic       hold_c;
    logic       hold_z;

    shift_pipe #(.WIDTH(8), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_type   (in_type),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    // Reference: {carry, result} from the shift rules using wide integer arithmetic.
    function automatic logic [8:0] ref_op(input logic [7:0] d, input logic [4:0] s,
                                          input logic [2:0] t);
        logic [63:0]        u;
        logic signed [63:0] v;
        logic [15:0]        dd;
        logic [7:0]         r;
        logic               c;
        int                 n;
        int                 m;
        n  = int'(s);
        m  = n % 8;
        dd = {d, d};
        r  = d;
        c  = 1'b0;
        case (t)
            3'd0: begin u = 64'(d) << n; r = u[7:0]; c = u[8]; end
            3'd1: begin u = (64'(d) << 32) >> n; r = u[39:32]; c = u[31]; end
            3'd2: begin
                v = $signed({{56{d[7]}}, d});
                v = (v <<< 32) >>> n;
                r = v[39:32];
                c = v[31];
            end
            3'd3: begin dd = dd << m; r = dd[15:8]; c = (n != 0) ? r[0] : 1'b0; end
            3'd4: begin dd = dd >> m; r = dd[7:0];  c = (n != 0) ? r[7] : 1'b0; end
            default: begin r = d; c = 1'b0; end
        endcase
        return {c, r};
    endfunction

    // Monitor: handshake rule, stall stability, scoreboard of accepted ops.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_q = 1'b0;
            end else begin
                chk("in_ready_rule", in_ready, !out_valid || out_ready);
                if (stall_q) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, hold_d);
                    chk("hold_carry", out_carry, hold_c);
                    chk("hold_zero", out_zero, hold_z);
                end
                if (in_valid && in_ready) begin
                    q_exp.push_back(ref_op(in_data, in_shamt, in_type));
                    acc_cnt++;
                end
                if (out_valid && out_ready) begin
                    chk("result_pending", q_exp.size() > 0, 1);
                    if (q_exp.size() > 0) begin
                        e = q_exp.pop_front();
                        chk("data", out_data, e[7:0]);
                        chk("carry", out_carry, e[8]);
                        chk("zero", out_zero, e[7:0] == 8'h00);
                    end
                    out_cnt++;
                    oc_q.push_back(cyc);
                end
                stall_q = out_valid && !out_ready;
                hold_d  = out_data;
                hold_c  = out_carry;
                hold_z  = out_zero;
            end
        end
    end

    task automatic run_dir(input string tag, input logic [2:0] t, input logic [7:0] d,
                           input logic [4:0] s, input logic [7:0] ed, input logic ec);
        int acc;
        int k;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_type   = t;
        in_data   = d;
        in_shamt  = s;
        @(negedge clk);
        acc = cyc;
        chk({tag, "_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk({tag, "_latency"}, cyc - acc, 3);
        chk({tag, "_data"}, out_data, ed);
        chk({tag, "_carry"}, out_carry, ec);
        chk({tag, "_zero"}, out_zero, ed == 8'h00);
    endtask

    // Hold in_valid with the given op until it is accepted; returns at posedge+1.
    task automatic send(input logic [2:0] t, input logic [7:0] d, input logic [4:0] s);
        logic ok;
        ok        = 1'b0;
        in_valid  = 1'b1;
        in_type   = t;
        in_data   = d;
        in_shamt  = s;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        if (!ok) chk("send_timeout", ok, 1);
    endtask

    initial begin
        int base;
        int k;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_type   = '0;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_carry", out_carry, 0);
        chk("rst_out_zero", out_zero, 1);
        chk("rst_in_ready", in_ready, 1);
        #10 rst_n = 1'b1;

        run_dir("lsl3",    3'd0, 8'h96, 5'd3,  8'hB0, 1'b0);
        run_dir("asr2",    3'd2, 8'h96, 5'd2,  8'hE5, 1'b1);
        run_dir("asr20",   3'd2, 8'h96, 5'd20, 8'hFF, 1'b1);
        run_dir("lsr9",    3'd1, 8'h96, 5'd9,  8'h00, 1'b0);
        run_dir("ror11",   3'd4, 8'h96, 5'd11, 8'hD2, 1'b1);
        run_dir("rol0",    3'd3, 8'h96, 5'd0,  8'h96, 1'b0);
        run_dir("pass7",   3'd7, 8'h96, 5'd5,  8'h96, 1'b0);
        run_dir("lsl8",    3'd0, 8'h97, 5'd8,  8'h00, 1'b1);
        run_dir("lsr8",    3'd1, 8'h96, 5'd8,  8'h00, 1'b1);
        run_dir("asr8",    3'd2, 8'h16, 5'd8,  8'h00, 1'b0);
        run_dir("rol8",    3'd3, 8'h97, 5'd8,  8'h97, 1'b1);
        run_dir("lsl0",    3'd0, 8'hFF, 5'd0,  8'hFF, 1'b0);

        // Back-to-back burst with a 4-cycle output stall after the first result.
        @(posedge clk); #1;
        base      = out_cnt;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) send(3'($urandom_range(0, 7)), 8'($urandom), 5'($urandom));
                in_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 50 && out_cnt == base; j++) @(posedge clk);
                #1 out_ready = 1'b0;
                #1 chk("bp_in_ready_low", in_ready, 0);
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        for (k = 0; k < 100 && out_cnt < base + 6; k++) @(posedge clk);
        chk("bp_count", out_cnt - base, 6);
        chk("bp_drained", q_exp.size(), 0);

        // Full throughput: 8 ops in 8 cycles come out on 8 consecutive cycles.
        @(posedge clk); #1;
        base = out_cnt;
        oc_q.delete();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_type  = 3'($urandom_range(0, 7));
            in_data  = 8'($urandom);
            in_shamt = 5'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (k = 0; k < 50 && out_cnt < base + 8; k++) @(posedge clk);
        chk("tput_count", out_cnt - base, 8);
        if (oc_q.size() >= 8) chk("tput_span", oc_q[7] - oc_q[0], 7);

        // Reset with three operations in flight.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_type  = 3'd1;
            in_data  = 8'($urandom);
            in_shamt = 5'($urandom_range(0, 7));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_carry", out_carry, 0);
        chk("mid_rst_out_zero", out_zero, 1);
        chk("mid_rst_in_ready", in_ready, 1);
        q_exp.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        base = out_cnt;
        run_dir("post_rst", 3'd0, 8'h96, 5'd3, 8'hB0, 1'b0);
        repeat (6) @(posedge clk);
        chk("post_rst_outputs", out_cnt - base, 1);

        // Randomized traffic with random source and sink pacing.
        base = acc_cnt;
        for (int c = 0; c < 60000 && (acc_cnt - base) < 10000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 8'($urandom);
            in_shamt  = 5'($urandom_range(0, 31));
            in_type   = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rand_accepts", (acc_cnt - base) >= 10000, 1);
        for (k = 0; k < 50 && q_exp.size() > 0; k++) @(posedge clk);
        chk("rand_drained", q_exp.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Pipelined, parametrised barrel shifter for the datapath's shift/rotate operations. Supports logical left/right, arithmetic right, rotate left/right and pass-through on a WIDTH-bit operand. One log2 stage per pipeline register, valid/ready handshakes on both sides, full throughput, and carry/zero flags for the ALU flag logic. It sits between operand fetch and the result/flag write-back stage, replacing the combinational shifter where WIDTH grows beyond 8.

## Interface
- WIDTH, 8, operand width; power of two, at least 4
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W > WIDTH
- NSTG, $clog2(WIDTH), derived localparam; equals the pipeline depth
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand/control presented
- in_ready  out  1  block accepts this cycle
- in_data  in  WIDTH  operand
- in_shamt  in  SHAMT_W  shift amount, unsigned
- in_type  in  3  shift type
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts this cycle
- out_data  out  WIDTH  result
- out_carry  out  1  last bit shifted/rotated out
- out_zero  out  1  high when out_data == 0

## Operation
- Shift type codes:
  - 000 LSL
  - 001 LSR
  - 010 ASR
  - 011 ROL
  - 100 ROR
  - 101–111 pass-through: data unchanged, carry 0
- Out-of-range amounts, where in_shamt >= WIDTH:
  - LSL and LSR give 0.
  - ASR gives all bits equal to in_data[WIDTH-1].
  - ROL and ROR use in_shamt mod WIDTH.
- Carry for shamt == 0: 0 for every type.
- Carry otherwise, by type:
  - LSL: in_data[WIDTH-shamt] for shamt ≤ WIDTH, else 0.
  - LSR: in_data[shamt-1] for shamt ≤ WIDTH, else 0.
  - ASR: in_data[shamt-1] for shamt < WIDTH, else in_data[WIDTH-1].
  - ROL: result[0].
  - ROR: result[WIDTH-1].
- Stage 0 work:
  - Decodes the type and the out-of-range condition (any in_shamt bit at position ≥ $clog2(WIDTH) set).
  - Computes the non-rotate carry.
  - Forms the fill bit.
- Stage k (k = 0..NSTG-1) applies a shift of 2**k when shamt bit k is set.
- The out-of-range override is applied in the final stage.
- Rotate carry and out_zero are derived combinationally from the final register.
- Results are bit-exact versus the golden model for every type, shamt and data value.

## Timing
- Each stage has its own valid bit plus payload (data, remaining shamt bits, type, saturate flag, pre-carry).
- Global advance enable en = !out_valid || out_ready.
  - When en is high, every stage loads from its predecessor.
  - When en is low, every stage holds.
- in_ready = en, purely combinational from out_valid and out_ready.
- Bubbles are not compressed.
- A transfer occurs on a cycle with in_valid && in_ready.
- Latency is NSTG cycles from accept to out_valid; 3 for WIDTH=8.
- Throughput is one result per cycle while out_ready is held high.
- While out_valid && !out_ready:
  - out_data, out_carry and out_zero are stable.
  - out_valid stays high.
- A cycle with in_valid low and en high inserts a bubble: the stage-0 valid bit clears.
- Reset asserted at any time, including mid-stream:
  - All valid bits clear immediately.
  - All payload registers clear to 0.
  - out_valid, out_data, out_carry = 0; out_zero = 1; in_ready = 1.
  - In-flight operations are discarded, with no partial output.
- First accept is possible on the first rising edge after rst_n deasserts.

## Structure
- Package shift_pkg holds:
  - Shift type localparams: SH_LSL, SH_LSR, SH_ASR, SH_ROL, SH_ROR.
  - The stage payload struct, parametrised by width via the package function/typedef pattern.
- Sub-module shift_stage is instantiated NSTG times by a generate loop. Per instance:
  - Parameters: WIDTH and stage index K.
  - Combinational conditional shift/rotate by 2**K.
  - Output register with en and asynchronous reset.
- Top level: stage-0 decode, final out-of-range override, flag logic, handshake.
- Target size is about 200–300 lines of RTL.

## Test plan
All scenarios use WIDTH=8.
- Reset then LSL: in_data 0x96, shamt 3 -> out_data 0xB0, carry 0, zero 0, out_valid exactly 3 cycles after accept.
- ASR: 0x96, shamt 2 -> 0xE5, carry 1. ASR 0x96, shamt 20 -> 0xFF, carry 1. LSR 0x96, shamt 9 -> 0x00, carry 0, zero 1.
- ROR: 0x96, shamt 11 -> 0xD2, carry 1. ROL 0x96, shamt 0 -> 0x96, carry 0. Type 111 -> 0x96, carry 0.
- Streaming and backpressure:
  - Send 6 back-to-back ops, then drop out_ready for 4 cycles after the first result.
  - Required: in_ready falls in that same cycle, outputs hold stable, no loss or duplication, order preserved.
  - Throughput returns to 1/cycle once out_ready rises.
- Reset mid-stream: assert rst_n low with 3 ops in flight -> out_valid 0 the same cycle. Post-release, the first new op returns its correct result with no stale output.
- Random: 10k random data/shamt/type with random in_valid/out_ready, checked against the reference model for data, carry and zero.
